// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage closing the PC -> imem -> PC loop.
// Optional FETCH_ALIGN_CHECK_EN: fault on a misaligned PC instead of masking it.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_next_o,
    output logic        pc_we_o,
    output logic        fetch_fault_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    if (MAX_WAIT < 1 || MAX_WAIT > 255 || RESET_PC[1:0] != 2'b00) begin : g_bad_param
        $error("instr_fetch_unit: parameter out of range");
    end

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:2] addr_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        fault_q;
    logic        misaligned;
    logic        timeout;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Last tolerated no-ack cycle; the ack branch is checked first.
    assign timeout = (wait_cnt == WAIT_LAST);

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign fetch_fault_o = fault_q;

    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = 32'd0;
        pc_we_o    = 1'b0;
        pc_next_o  = redirect_i ? redirect_pc_i : pc_i + 32'd4;
        unique case (state)
            IDLE: pc_we_o = redirect_i;
            REQ: begin
                pc_we_o = redirect_i;
                if (!misaligned) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {pc_i[31:2], 2'b00};
                end
            end
            HOLD: pc_we_o = redirect_i || !stall_i;
            DRAIN: begin
                pc_we_o    = redirect_i;
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_q, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            addr_q   <= '0;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    wait_cnt <= 8'd0;
                end
                REQ: begin
                    addr_q <= pc_i[31:2];
                    if (misaligned) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else if (mem_ack_i) begin
                        wait_cnt <= 8'd0;
                        if (!redirect_i) begin
                            instr_q <= mem_rdata_i;
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end
                    end else if (timeout) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (redirect_i)
                            state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect_i || !stall_i) begin
                        state    <= REQ;
                        valid_q  <= 1'b0;
                        wait_cnt <= 8'd0;
                    end
                end
                DRAIN: begin
                    // Old request still owns the bus; its data is dropped.
                    if (mem_ack_i) begin
                        state    <= REQ;
                        wait_cnt <= 8'd0;
                    end else if (timeout) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                FAULT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register + latency-programmable memory,
// scoreboard of expected instructions compared when instr_valid_o rises.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_next_o;
    logic        pc_we_o;
    logic        fetch_fault_o;

    int n_chk  = 0;
    int n_fail = 0;
    int lat    = 0;
    int waited = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_o      (instr_o),
        .instr_valid_o(instr_valid_o),
        .pc_next_o    (pc_next_o),
        .pc_we_o      (pc_we_o),
        .fetch_fault_o(fetch_fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ((a ^ 32'h0040_0000) * 32'h0000_9E37) + 32'h2008_0005;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back('{pc, memf(pc)});
    endtask

    // PC register the fetch stage drives
    always @(posedge clk) begin
        if (rst)
            pc_i <= 32'h0040_0000;
        else if (pc_we_o)
            pc_i <= pc_next_o;
    end

    // Memory: acks after `lat` no-ack cycles of a continuous request
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o === 1'b1) begin
                if (waited >= lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = memf(mem_addr_o);
                    waited      = 0;
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = 32'hDEAD_BEEF;
                    waited++;
                end
            end else begin
                mem_ack_i = 1'b0;
                waited    = 0;
            end
        end
    end

    // Scoreboard monitor: one pop per new valid instruction
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            half();
            if (instr_valid_o === 1'b1 && !prev_v) begin
                if (sb.size() == 0) begin
                    check("sb_extra_instr", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_instr", instr_o, e.instr);
                    check("sb_pc", pc_i, e.pc);
                end
            end
            prev_v = (instr_valid_o === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded bound", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        push(32'h0040_0000);
        push(32'h0040_0004);
        push(32'h0040_0008);
        push(32'h0040_0100);
        push(32'hFFFF_FFFC);
        push(32'h0000_0000);
`ifndef FETCH_ALIGN_CHECK_EN
        sb.push_back('{32'h0040_0002, memf(32'h0040_0000)});
`endif
        tick();
        tick();
        rst = 1'b0;
        half();
        check("rst_req", mem_req_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_we", pc_we_o, 1'b0);
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_fault", fetch_fault_o, 1'b0);

        tick();
        half();
        check("zw_req", mem_req_o, 1'b1);
        check("zw_addr", mem_addr_o, 32'h0040_0000);
        check("zw_valid_lo", instr_valid_o, 1'b0);

        tick();
        half();
        check("zw_valid", instr_valid_o, 1'b1);
        check("zw_instr", instr_o, 32'h2008_0005);
        check("zw_we", pc_we_o, 1'b1);
        check("zw_next", pc_next_o, 32'h0040_0004);

        tick();
        stall_i = 1'b1;
        half();
        check("seq_addr", mem_addr_o, 32'h0040_0004);

        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2)
                lat = 2;
            half();
            check("stall_we", pc_we_o, 1'b0);
            check("stall_instr", instr_o, memf(32'h0040_0004));
            check("stall_valid", instr_valid_o, 1'b1);
        end

        tick();
        stall_i = 1'b0;
        half();
        check("unstall_we", pc_we_o, 1'b1);
        check("unstall_next", pc_next_o, 32'h0040_0008);

        for (int i = 0; i < 3; i++) begin
            tick();
            half();
            check("ws_req", mem_req_o, 1'b1);
            check("ws_addr", mem_addr_o, 32'h0040_0008);
            check("ws_valid_lo", instr_valid_o, 1'b0);
        end

        tick();
        half();
        check("ws_valid", instr_valid_o, 1'b1);
        check("ws_next", pc_next_o, 32'h0040_000C);

        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0100;
        half();
        check("rd_we", pc_we_o, 1'b1);
        check("rd_next", pc_next_o, 32'h0040_0100);
        check("rd_addr", mem_addr_o, 32'h0040_000C);

        tick();
        redirect_i = 1'b0;
        half();
        check("drain_req", mem_req_o, 1'b1);
        check("drain_addr", mem_addr_o, 32'h0040_000C);

        tick();
        lat = 0;
        half();
        check("drain_addr2", mem_addr_o, 32'h0040_000C);

        tick();
        half();
        check("rd_tgt_addr", mem_addr_o, 32'h0040_0100);
        check("rd_valid_lo", instr_valid_o, 1'b0);

        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        half();
        check("hold_rd_we", pc_we_o, 1'b1);
        check("hold_rd_next", pc_next_o, 32'hFFFF_FFFC);

        tick();
        redirect_i = 1'b0;
        half();
        check("hold_rd_drop", instr_valid_o, 1'b0);
        check("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);

        tick();
        half();
        check("wrap_we", pc_we_o, 1'b1);
        check("wrap_next", pc_next_o, 32'h0000_0000);

        tick();
        half();
        check("wrap_addr0", mem_addr_o, 32'h0000_0000);

        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0002;
        half();

        tick();
        redirect_i = 1'b0;
        half();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_req", mem_req_o, 1'b0);
`else
        check("mis_req", mem_req_o, 1'b1);
        check("mis_addr", mem_addr_o, 32'h0040_0000);
`endif

        tick();
        stall_i = 1'b1;
        half();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_fault", fetch_fault_o, 1'b1);
        check("mis_valid", instr_valid_o, 1'b0);
`else
        check("mis_fault", fetch_fault_o, 1'b0);
        check("mis_valid", instr_valid_o, 1'b1);
`endif

        tick();
        rst = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        stall_i = 1'b0;
        lat     = 1000;
        half();
        check("to_idle_req", mem_req_o, 1'b0);
        check("to_idle_fault", fetch_fault_o, 1'b0);

        for (int k = 1; k <= 15; k++) begin
            tick();
            half();
            check("to_wait_req", mem_req_o, 1'b1);
            check("to_wait_fault", fetch_fault_o, 1'b0);
        end

        for (int k = 0; k < 3; k++) begin
            tick();
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h1234_5678;
            half();
            check("to_fault", fetch_fault_o, 1'b1);
            check("to_req", mem_req_o, 1'b0);
            check("to_we", pc_we_o, 1'b0);
            check("to_valid", instr_valid_o, 1'b0);
        end

        tick();
        redirect_i = 1'b0;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        half();
        check("to_rst_clear", fetch_fault_o, 1'b0);
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
